instr_prefetch_queue: RTL and testbench

Fetch-side prefetch buffer between instruction memory and the IF/ID pipeline register. It issues sequential word fetches, holds up to DEPTH returned instructions with their PCs, and presents them to decode as `if_id_type` over a valid/ready handshake. On a redirect (branch or jump target) it empties the queue, discards responses still in flight, and restarts fetch at the new PC.

---
 rtl/common.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/instr_prefetch_queue.sv | 111 +++++++++++
 tb/tb_instr_prefetch_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared fetch/decode types and the architectural reset vector.
package common;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   typedef logic [31:0] instruction_type;

   typedef struct packed {
      logic [31:0]     pc;
      instruction_type instruction;
      logic            decpompress_failed;
   } if_id_type;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_type;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; DEPTH must be a power of two >= 2.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             do_push, do_pop;

   always_comb begin
      full    = (count == CW'(DEPTH));
      empty   = (count == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;
      rdata   = mem[rd_ptr];
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         mem    <= '{default: '0};
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited fetch issue, in-order response
// buffering with PC tags, and flush/restart on redirect.
module instr_prefetch_queue
   import common::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output if_id_type   out_data
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   q_count, tag_count;
   logic [CW:0]     occupancy;
   logic [31:0]     tag_pc;
   fetch_entry_type q_wdata, q_rdata;
   logic            q_push, q_pop, q_full, q_empty;
   logic            tag_full, tag_empty, gnt_fire;

   always_comb begin
      occupancy = {1'b0, q_count} + {1'b0, outstanding_q};
      imem_req  = reset_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
      imem_addr = fetch_pc_q;
      gnt_fire  = imem_req && imem_gnt;
      q_push    = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
      out_valid = !q_empty && !redirect_valid;
      q_pop     = out_valid && out_ready;
      q_wdata   = '{pc: tag_pc, instr: imem_rdata};
      out_data  = '{pc: q_rdata.pc, instruction: q_rdata.instr, decpompress_failed: 1'b0};
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid);
      drop_cnt_d    = drop_cnt_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // Pending drops are already part of outstanding, so every live request becomes a drop.
         drop_cnt_d = outstanding_q - CW'(imem_rvalid);
      end else begin
         if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_type)),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (q_push),
      .pop     (q_pop),
      .clear   (redirect_valid),
      .wdata   (q_wdata),
      .rdata   (q_rdata),
      .full    (q_full),
      .empty   (q_empty),
      .count   (q_count)
   );

   // Tags survive a redirect so that dropped responses still consume their entry.
   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_tags (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (gnt_fire),
      .pop     (imem_rvalid),
      .clear   (1'b0),
      .wdata   (fetch_pc_q),
      .rdata   (tag_pc),
      .full    (tag_full),
      .empty   (tag_empty),
      .count   (tag_count)
   );

   assert property (@(posedge clk) disable iff (!reset_n) q_push |-> !q_full);
   assert property (@(posedge clk) disable iff (!reset_n) gnt_fire |-> !tag_full);
   assert property (@(posedge clk) disable iff (!reset_n) imem_rvalid |-> !tag_empty);
   assert property (@(posedge clk) disable iff (!reset_n) tag_count == outstanding_q);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomised bench for instr_prefetch_queue: memory model, scoreboard of expected fetches,
// and an independent output monitor.
module tb_instr_prefetch_queue;
   import common::*;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   if_id_type   out_data;

   instr_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   mem_req_t    mem_q[$];   // requests accepted by memory, oldest first
   logic [31:0] exp_q[$];   // PCs that decode must still receive, in order
   int          stale;      // in-flight responses belonging to a flushed stream
   logic [31:0] exp_fetch_pc;
   int          dcyc;
   int          last_due;
   int          lat_min, lat_max;
   int          gnt_pct, rdy_pct, redir_pct;
   bit          release_now;
   int          n_checks, n_fail, n_out;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input bit ok, input string name, input logic [64:0] act,
                        input logic [64:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory + reference model: every grant pushes the expected output into exp_q.
   initial begin : model
      int due;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mem_q.delete();
            exp_q.delete();
            stale        = 0;
            exp_fetch_pc = RPC;
            last_due     = 0;
         end else begin
            if (imem_rvalid && mem_q.size() > 0) begin
               void'(mem_q.pop_front());
               if (stale > 0) stale--;
            end
            if (redirect_valid) begin
               exp_q.delete();
               stale        = mem_q.size();
               exp_fetch_pc = {redirect_pc[31:2], 2'b00};
            end
            if (imem_req && imem_gnt) begin
               check(imem_addr == exp_fetch_pc, "imem_addr", imem_addr, exp_fetch_pc);
               due = dcyc + $urandom_range(lat_max, lat_min);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               mem_q.push_back('{addr: imem_addr, due: due});
               exp_q.push_back(exp_fetch_pc);
               exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
         end
      end
   end

   // Output monitor: pops the scoreboard on every accepted instruction.
   initial begin : monitor
      logic [31:0] e;
      logic [64:0] exp_d;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (redirect_valid) check(!out_valid, "out_valid_in_redirect", out_valid, 0);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_output", out_data, 0);
               end else begin
                  e     = exp_q.pop_front();
                  exp_d = {e, mem_word(e), 1'b0};
                  check(out_data == exp_d, "out_data", out_data, exp_d);
                  n_out++;
               end
            end
         end
      end
   end

   task automatic step(input bit force_redir, input logic [31:0] rpc);
      bit exp_req;
      @(posedge clk);
      #1;
      dcyc++;
      if (release_now) begin
         reset_n     = 1'b1;
         release_now = 1'b0;
      end
      imem_gnt       = ($urandom_range(99) < gnt_pct);
      out_ready      = ($urandom_range(99) < rdy_pct);
      redirect_valid = force_redir ||
                       (reset_n && stale == 0 && $urandom_range(99) < redir_pct);
      redirect_pc    = force_redir ? rpc : $urandom;
      if (reset_n && mem_q.size() > 0 && mem_q[0].due <= dcyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mem_q[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      if (reset_n) begin
         exp_req = !redirect_valid && (exp_q.size() + stale < DEPTH);
         check(imem_req == exp_req, "imem_req", imem_req, exp_req);
      end
   endtask

   task automatic set_mode(input int g, input int r, input int d, input int lmin, input int lmax);
      gnt_pct = g; rdy_pct = r; redir_pct = d; lat_min = lmin; lat_max = lmax;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n        = 1'b0;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check(!out_valid, "reset_out_valid", out_valid, 0);
      check(!imem_req, "reset_imem_req", imem_req, 0);
      check(out_data == '0, "reset_out_data", out_data, 0);
      @(negedge clk);
      release_now = 1'b1;
   endtask

   initial begin
      int guard;
      reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      release_now = 1'b0; dcyc = 0; n_checks = 0; n_fail = 0; n_out = 0;
      set_mode(100, 100, 0, 1, 1);
      repeat (2) @(negedge clk);
      check(!imem_req, "reset_imem_req", imem_req, 0);
      check(!out_valid, "reset_out_valid", out_valid, 0);
      check(out_data == '0, "reset_out_data", out_data, 0);
      release_now = 1'b1;

      // Streaming from RESET_PC with 1-cycle memory: first output in cycle 2, then 1/cycle.
      for (int i = 0; i < 20; i++) begin
         step(1'b0, '0);
         if (i == 0) check(imem_addr == RPC, "first_req_addr", imem_addr, RPC);
         check(out_valid == (i >= 2), "stream_valid", out_valid, i >= 2);
      end

      // Backpressure: credit limit stops requests, held entries drain in order.
      set_mode(100, 0, 0, 1, 1);
      repeat (10) step(1'b0, '0);
      check(out_valid, "held_valid", out_valid, 1);
      set_mode(100, 100, 0, 1, 1);
      repeat (10) step(1'b0, '0);

      // Redirect with stale responses in flight on a 3-cycle memory.
      set_mode(100, 100, 0, 3, 3);
      repeat (8) step(1'b0, '0);
      step(1'b1, 32'h0000_2002);
      step(1'b0, '0);
      check(imem_addr == 32'h0000_2000, "redirect_addr", imem_addr, 32'h0000_2000);
      repeat (15) step(1'b0, '0);

      // Redirect landing on a response with out_ready high.
      set_mode(100, 100, 0, 1, 1);
      repeat (8) step(1'b0, '0);
      step(1'b1, 32'h0000_3000);
      check(!out_valid, "redir_rvalid_out_valid", out_valid, 0);
      repeat (8) step(1'b0, '0);

      // Address wrap.
      step(1'b1, 32'hFFFF_FFF8);
      repeat (10) step(1'b0, '0);

      // Random traffic with random redirects.
      for (int blk = 0; blk < 15; blk++) begin
         set_mode($urandom_range(100, 30), $urandom_range(100, 20), 4, 1, $urandom_range(4, 1));
         repeat (100) step(1'b0, '0);
      end

      // Mid-run reset with requests outstanding and entries buffered.
      set_mode(100, 0, 0, 3, 3);
      guard = 0;
      do begin
         step(1'b0, '0);
         guard++;
      end while (!(mem_q.size() >= 1 && exp_q.size() > mem_q.size()) && guard < 50);
      check(guard < 50, "midrun_setup_timeout", guard, 50);
      do_reset();
      set_mode(100, 100, 0, 1, 2);
      step(1'b0, '0);
      check(imem_addr == RPC, "restart_addr", imem_addr, RPC);
      for (int blk = 0; blk < 5; blk++) begin
         set_mode($urandom_range(100, 30), $urandom_range(100, 20), 4, 1, $urandom_range(4, 1));
         repeat (100) step(1'b0, '0);
      end

      // Drain: no new grants, everything expected must come out.
      set_mode(0, 100, 0, 1, 1);
      repeat (30) step(1'b0, '0);
      check(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
      check(n_out > 200, "output_volume", n_out, 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
